// File: rtl/dispatch_ctrl_pkg.sv
// Shared constants, state encoding and opcode helper for the dispatch stage.
package dispatch_ctrl_pkg;

  localparam int DATA_WIDTH        = 32;
  localparam int INSTRUCTION_WIDTH = 32;
  localparam int OP_RANGE          = 7;

  localparam logic [6:0]  LOAD_OP  = 7'b0000011;
  localparam logic [6:0]  STORE_OP = 7'b0100011;
  localparam logic [31:0] NOP_INST = 32'h00000013;

  typedef enum logic {
    DISPATCH_RUN   = 1'b0,
    DISPATCH_FLUSH = 1'b1
  } dispatch_state_t;

  function automatic logic is_mem_op(input logic [INSTRUCTION_WIDTH-1:0] inst);
    return (inst[OP_RANGE-1:0] == LOAD_OP) || (inst[OP_RANGE-1:0] == STORE_OP);
  endfunction

endpackage

// File: rtl/dispatch_ctrl_inst_fifo.sv
// Circular instruction buffer: push at tail, pop at head, clear on flush.
module inst_fifo
  import dispatch_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear,
  input  logic [INSTRUCTION_WIDTH-1:0] wr_inst,
  input  logic [DATA_WIDTH-1:0]        wr_pc,
  input  logic                         wr_pred,
  output logic [$clog2(DEPTH):0]       count,
  output logic [INSTRUCTION_WIDTH-1:0] head_inst,
  output logic [DATA_WIDTH-1:0]        head_pc,
  output logic                         head_pred
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [INSTRUCTION_WIDTH-1:0] mem_inst [DEPTH];
  logic [DATA_WIDTH-1:0]        mem_pc   [DEPTH];
  logic                         mem_pred [DEPTH];
  logic [PW-1:0]                head;
  logic [PW-1:0]                tail;

  // Storage and pointer update; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= {PW{1'b0}};
      tail  <= {PW{1'b0}};
      count <= {(PW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_inst[i] <= {INSTRUCTION_WIDTH{1'b0}};
        mem_pc[i]   <= {DATA_WIDTH{1'b0}};
        mem_pred[i] <= 1'b0;
      end
    end else if (clear) begin
      head  <= {PW{1'b0}};
      tail  <= {PW{1'b0}};
      count <= {(PW+1){1'b0}};
    end else begin
      if (push) begin
        mem_inst[tail] <= wr_inst;
        mem_pc[tail]   <= wr_pc;
        mem_pred[tail] <= wr_pred;
        tail           <= tail + PTR_ONE;
      end
      if (pop) begin
        head <= head + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign head_inst = (count != {(PW+1){1'b0}}) ? mem_inst[head] : {INSTRUCTION_WIDTH{1'b0}};
  assign head_pc   = (count != {(PW+1){1'b0}}) ? mem_pc[head]   : {DATA_WIDTH{1'b0}};
  assign head_pred = (count != {(PW+1){1'b0}}) ? mem_pred[head] : 1'b0;

endmodule

// File: rtl/dispatch_ctrl.sv
// Dispatch sequencer: buffers fetched instructions and feeds decode when
// ROB/RS/LSQ have room; blocks for a fixed recovery window after a flush.
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_fetch_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] in_fetch_inst,
  input  logic [DATA_WIDTH-1:0]        in_fetch_pc,
  input  logic                         in_fetch_predicted_taken,
  output logic                         out_fetch_ready,
  input  logic                         in_rob_almost_full,
  input  logic                         in_rs_almost_full,
  input  logic                         in_lsq_almost_full,
  input  logic                         in_flush,
  output logic                         out_decode_ena,
  output logic [INSTRUCTION_WIDTH-1:0] out_inst,
  output logic [DATA_WIDTH-1:0]        out_current_pc,
  output logic                         out_predicted_taken
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  dispatch_state_t state;
  logic [2:0]      cnt;
  logic [PW:0]     count;
  logic            push;
  logic            run;
  logic            is_mem;

  assign run             = (state == DISPATCH_RUN) && !in_flush;
  assign is_mem          = is_mem_op(out_inst);
  assign out_fetch_ready = (count != FULL_CNT) && run;
  assign out_decode_ena  = run && (count != {(PW+1){1'b0}}) && !in_rob_almost_full
                           && !in_rs_almost_full && !(is_mem && in_lsq_almost_full);
  assign push            = in_fetch_valid && out_fetch_ready;

  // Recovery FSM: a flush (even one arriving mid-recovery) reloads the hold counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DISPATCH_RUN;
      cnt   <= 3'd0;
    end else if (in_flush) begin
      state <= DISPATCH_FLUSH;
      cnt   <= 3'(FLUSH_CYCLES - 1);
    end else begin
      case (state)
        DISPATCH_RUN: begin
          state <= DISPATCH_RUN;
          cnt   <= cnt;
        end
        DISPATCH_FLUSH: begin
          if (cnt == 3'd0) begin
            state <= DISPATCH_RUN;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: begin
          state <= DISPATCH_RUN;
          cnt   <= 3'd0;
        end
      endcase
    end
  end

  inst_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (out_decode_ena),
    .clear     (in_flush),
    .wr_inst   (in_fetch_inst),
    .wr_pc     (in_fetch_pc),
    .wr_pred   (in_fetch_predicted_taken),
    .count     (count),
    .head_inst (out_inst),
    .head_pc   (out_current_pc),
    .head_pred (out_predicted_taken)
  );

endmodule
